// File: rtl/rib_pkg.sv
// Shared types for the internal bus arbiter/router.
// Holds the FSM state enum and the master index constants.
package rib_pkg;

    typedef enum logic [1:0] {
        RIB_IDLE   = 2'd0,
        RIB_ACCESS = 2'd1,
        RIB_RESP   = 2'd2
    } rib_state_e;

    localparam logic [1:0] RIB_M_IF  = 2'd0;
    localparam logic [1:0] RIB_M_LS  = 2'd1;
    localparam logic [1:0] RIB_M_DBG = 2'd2;

endpackage

// File: rtl/rib_prio_enc.sv
// Fixed-priority grant encoder: M2 > M1 > M0.
// Ports: req (3 request bits) -> gnt (winner index), valid (any request).
module rib_prio_enc
    import rib_pkg::*;
(
    input  logic [2:0] req,
    output logic [1:0] gnt,
    output logic       valid
);

    always_comb begin
        gnt   = RIB_M_IF;
        valid = |req;
        if (req[2]) begin
            gnt = RIB_M_DBG;
        end else if (req[1]) begin
            gnt = RIB_M_LS;
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Three-master to NUM_SLV-slave single-beat bus arbiter and router.
// Ports: clk_i/rst_i, per-master req/we/addr/wdata in and
// rdata/done/err out, registered slave strobes s_*, packed
// slave read data s_rdata_i, and hold_o stall request.
module rib_arbiter
    import rib_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_MSB = 31,
    parameter int SEL_LSB = 28
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      m0_req_i,
    input  logic                      m0_we_i,
    input  logic [ADDR_W-1:0]         m0_addr_i,
    input  logic [DATA_W-1:0]         m0_wdata_i,
    output logic [DATA_W-1:0]         m0_rdata_o,
    output logic                      m0_done_o,
    output logic                      m0_err_o,
    input  logic                      m1_req_i,
    input  logic                      m1_we_i,
    input  logic [ADDR_W-1:0]         m1_addr_i,
    input  logic [DATA_W-1:0]         m1_wdata_i,
    output logic [DATA_W-1:0]         m1_rdata_o,
    output logic                      m1_done_o,
    output logic                      m1_err_o,
    input  logic                      m2_req_i,
    input  logic                      m2_we_i,
    input  logic [ADDR_W-1:0]         m2_addr_i,
    input  logic [DATA_W-1:0]         m2_wdata_i,
    output logic [DATA_W-1:0]         m2_rdata_o,
    output logic                      m2_done_o,
    output logic                      m2_err_o,
    output logic [NUM_SLV-1:0]        s_sel_o,
    output logic                      s_we_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata_i,
    output logic                      hold_o
);

    localparam int SW = SEL_MSB - SEL_LSB + 1;

    rib_state_e state_q, state_d;

    logic [1:0]         gnt, gnt_q;
    logic               gnt_vld;
    logic               we_d, we_q;
    logic [ADDR_W-1:0]  addr_d, addr_q;
    logic [DATA_W-1:0]  wdata_d, wdata_q;
    logic [SW-1:0]      idx_d;
    logic [NUM_SLV-1:0] sel_d, sel_q, tgt_q;
    logic               swe_q, bad_q;
    logic               load;
    logic               done_any, err_any;
    logic [DATA_W-1:0]  rd_sel, rd_any;

    rib_prio_enc u_prio (
        .req   ({m2_req_i, m1_req_i, m0_req_i}),
        .gnt   (gnt),
        .valid (gnt_vld)
    );

    always_comb begin
        we_d    = m0_we_i;
        addr_d  = m0_addr_i;
        wdata_d = m0_wdata_i;
        case (gnt)
            RIB_M_DBG: begin
                we_d    = m2_we_i;
                addr_d  = m2_addr_i;
                wdata_d = m2_wdata_i;
            end
            RIB_M_LS: begin
                we_d    = m1_we_i;
                addr_d  = m1_addr_i;
                wdata_d = m1_wdata_i;
            end
            default: ;
        endcase
    end

    // An out-of-range select field leaves sel_d all-zero,
    // which doubles as the decode-error flag.
    always_comb begin
        idx_d = addr_d[SEL_MSB:SEL_LSB];
        sel_d = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (idx_d == k[SW-1:0]) begin
                sel_d[k] = 1'b1;
            end
        end
    end

    assign load = (state_q == RIB_IDLE) && gnt_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RIB_IDLE:   if (gnt_vld) state_d = RIB_ACCESS;
            RIB_ACCESS: state_d = (bad_q || we_q) ? RIB_IDLE : RIB_RESP;
            RIB_RESP:   state_d = RIB_IDLE;
            default:    state_d = RIB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RIB_IDLE;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tgt_q   <= '0;
            bad_q   <= 1'b0;
            sel_q   <= '0;
            swe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                gnt_q   <= gnt;
                we_q    <= we_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                tgt_q   <= sel_d;
                bad_q   <= ~|sel_d;
                sel_q   <= sel_d;
                swe_q   <= we_d & (|sel_d);
            end else begin
                // Strobes live only for the single ACCESS cycle.
                sel_q <= '0;
                swe_q <= 1'b0;
            end
        end
    end

    assign s_sel_o   = sel_q;
    assign s_we_o    = swe_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (tgt_q[k]) begin
                rd_sel = rd_sel | s_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign done_any = ((state_q == RIB_ACCESS) && (bad_q || we_q))
                    || (state_q == RIB_RESP);
    assign err_any  = (state_q == RIB_ACCESS) && bad_q;
    assign rd_any   = (state_q == RIB_RESP) ? rd_sel : '0;

    assign m0_done_o  = done_any && (gnt_q == RIB_M_IF);
    assign m1_done_o  = done_any && (gnt_q == RIB_M_LS);
    assign m2_done_o  = done_any && (gnt_q == RIB_M_DBG);
    assign m0_err_o   = err_any && (gnt_q == RIB_M_IF);
    assign m1_err_o   = err_any && (gnt_q == RIB_M_LS);
    assign m2_err_o   = err_any && (gnt_q == RIB_M_DBG);
    assign m0_rdata_o = (gnt_q == RIB_M_IF) ? rd_any : '0;
    assign m1_rdata_o = (gnt_q == RIB_M_LS) ? rd_any : '0;
    assign m2_rdata_o = (gnt_q == RIB_M_DBG) ? rd_any : '0;

    assign hold_o = m1_req_i & ~m1_done_o;

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter.
// Scoreboard of per-master expected completions plus directed timing checks.
module tb_rib_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  done;
    logic [2:0]  err;
    logic [3:0]  s_sel;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [127:0] s_rdata;
    logic        hold;

    logic [31:0] rd [4];
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    exp_t exp_q [3][$];
    exp_t e;
    int   order [$];
    int   n_chk;
    int   n_fail;
    int   lat;

    rib_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0_req_i   (req[0]),
        .m0_we_i    (we[0]),
        .m0_addr_i  (addr[0]),
        .m0_wdata_i (wdata[0]),
        .m0_rdata_o (rdata[0]),
        .m0_done_o  (done[0]),
        .m0_err_o   (err[0]),
        .m1_req_i   (req[1]),
        .m1_we_i    (we[1]),
        .m1_addr_i  (addr[1]),
        .m1_wdata_i (wdata[1]),
        .m1_rdata_o (rdata[1]),
        .m1_done_o  (done[1]),
        .m1_err_o   (err[1]),
        .m2_req_i   (req[2]),
        .m2_we_i    (we[2]),
        .m2_addr_i  (addr[2]),
        .m2_wdata_i (wdata[2]),
        .m2_rdata_o (rdata[2]),
        .m2_done_o  (done[2]),
        .m2_err_o   (err[2]),
        .s_sel_o    (s_sel),
        .s_we_o     (s_we),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_rdata_i  (s_rdata),
        .hold_o     (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slook(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : ~a;
    endfunction

    function automatic logic [31:0] rlook(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : ~a;
    endfunction

    // Slave model: read data appears the cycle after select.
    assign s_rdata = {rd[3], rd[2], rd[1], rd[0]};
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                rd[k] <= '0;
            end else if (s_sel[k]) begin
                if (s_we) smem[s_addr] = s_wdata;
                else rd[k] <= slook(s_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (|done) begin
            chk("one_done", 64'($countones(done)), 64'd1);
            for (int m = 0; m < 3; m++) begin
                if (done[m]) begin
                    order.push_back(m);
                    if (exp_q[m].size() == 0) begin
                        chk("unexp_done", 64'(m), 64'd99);
                    end else begin
                        e = exp_q[m].pop_front();
                        chk("rdata", 64'(rdata[m]), 64'(e.rdata));
                        chk("err", 64'(err[m]), 64'(e.err));
                        if (e.err) chk("err_sel", 64'(s_sel), 64'd0);
                    end
                end else begin
                    chk("idle_rdata", 64'(rdata[m]), 64'd0);
                    chk("idle_err", 64'(err[m]), 64'd0);
                end
            end
        end
    end

    task automatic issue(input int m, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        x.err   = (a[31:28] >= 4'd4);
        x.rdata = (x.err || w) ? 32'd0 : rlook(a);
        if (w && !x.err) rmem[a] = d;
        exp_q[m].push_back(x);
        we[m]    = w;
        addr[m]  = a;
        wdata[m] = d;
        req[m]   = 1'b1;
    endtask

    task automatic wait_done(input int m, output int l);
        l = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done[m]) begin
                l = i;
                break;
            end
        end
        if (l == 0) chk("timeout", 64'(m), 64'd99);
        @(posedge clk);
        #1;
        req[m] = 1'b0;
    endtask

    task automatic txn(input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int explat);
        int l;
        @(posedge clk);
        #1;
        issue(m, w, a, d);
        wait_done(m, l);
        if (explat > 0) chk("lat", 64'(l), 64'(explat));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = '0;
        we     = '0;
        for (int m = 0; m < 3; m++) begin
            addr[m]  = '0;
            wdata[m] = '0;
        end
        smem[32'h0000_0100] = 32'h0000_0013;
        rmem[32'h0000_0100] = 32'h0000_0013;

        @(negedge clk);
        chk("rst_sel", 64'(s_sel), 64'd0);
        chk("rst_we", 64'(s_we), 64'd0);
        chk("rst_addr", 64'(s_addr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hold", 64'(hold), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single write with strobe timing.
        @(posedge clk);
        #1;
        issue(1, 1'b1, 32'h1000_0040, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_hold_T", 64'(hold), 64'd1);
        chk("wr_sel_T", 64'(s_sel), 64'd0);
        @(negedge clk);
        chk("wr_sel", 64'(s_sel), 64'b0010);
        chk("wr_we", 64'(s_we), 64'd1);
        chk("wr_addr", 64'(s_addr), 64'h1000_0040);
        chk("wr_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("wr_done", 64'(done[1]), 64'd1);
        @(posedge clk);
        #1;
        req[1] = 1'b0;

        txn(0, 1'b0, 32'h0000_0100, 32'h0, 3);
        txn(1, 1'b0, 32'h1000_0040, 32'h0, 3);
        txn(2, 1'b0, 32'h3000_0008, 32'h0, 3);
        txn(0, 1'b1, 32'h2000_0020, 32'h1234_5678, 2);
        txn(2, 1'b0, 32'h2000_0020, 32'h0, 3);

        // Decode errors on read and write.
        txn(2, 1'b0, 32'h5000_0000, 32'h0, 2);
        txn(0, 1'b1, 32'hF000_0000, 32'hCAFE_F00D, 2);

        // Simultaneous requests complete in priority order.
        order.delete();
        fork
            txn(0, 1'b0, 32'h0000_0100, 32'h0, 0);
            txn(1, 1'b1, 32'h1000_0080, 32'h0BAD_F00D, 0);
            txn(2, 1'b0, 32'h3000_0010, 32'h0, 0);
        join
        chk("arb_n", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            chk("arb_0", 64'(order[0]), 64'd2);
            chk("arb_1", 64'(order[1]), 64'd1);
            chk("arb_2", 64'(order[2]), 64'd0);
        end
        txn(1, 1'b0, 32'h1000_0080, 32'h0, 3);

        // Late high-priority arrival does not pre-empt.
        order.delete();
        fork
            txn(0, 1'b0, 32'h0000_0200, 32'h0, 3);
            begin
                int l;
                @(posedge clk);
                @(posedge clk);
                #1;
                issue(2, 1'b0, 32'h2000_0010, 32'h0);
                wait_done(2, l);
            end
        join
        chk("late_n", 64'(order.size()), 64'd2);
        if (order.size() == 2) begin
            chk("late_0", 64'(order[0]), 64'd0);
            chk("late_1", 64'(order[1]), 64'd2);
        end

        // Reset in ACCESS: no done, re-grant afterwards.
        @(posedge clk);
        #1;
        issue(1, 1'b0, 32'h1000_0040, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_sel", 64'(s_sel), 64'b0010);
        rst = 1'b1;
        #1;
        chk("rst_mid_sel", 64'(s_sel), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_hold", 64'(hold), 64'd1);
        @(negedge clk);
        chk("rst_hold_sel", 64'(s_sel), 64'd0);
        rst = 1'b0;
        wait_done(1, lat);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q[0].size() + exp_q[1].size()
            + exp_q[2].size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/rib_arbiter.md
# rib_arbiter

Internal bus arbiter/router between the core's master ports and the memory-mapped slaves. It arbitrates among three masters:

- **M0:** instruction fetch.
- **M1:** core load/store.
- **M2:** debug master.

It decodes the winning address onto one of NUM_SLV slaves, sequences the single-beat read or write, and returns the response to the winner. It also produces the pipeline hold request that the control block uses to stall the core while a load/store is outstanding.

## Interface

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_SLV, 4, number of slaves, ≤ 16.
- SEL_MSB, 31, upper bit of slave-select field.
- SEL_LSB, 28, lower bit of slave-select field.

Ports:
- clk_i  in  1  clock; everything on the rising edge.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- mN_req_i  in  1  request from master N (N = 0, 1, 2); held high with fields stable until mN_done_o.
- mN_we_i  in  1  1 = write, 0 = read.
- mN_addr_i  in  ADDR_W  byte address.
- mN_wdata_i  in  DATA_W  write data.
- mN_rdata_o  out  DATA_W  read data; valid only while mN_done_o is high.
- mN_done_o  out  1  one-cycle completion pulse.
- mN_err_o  out  1  decode error; qualifies mN_done_o.
- s_sel_o  out  NUM_SLV  one-hot slave select.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_rdata_i  in  NUM_SLV*DATA_W  packed slave read data; slave k occupies bits [k*DATA_W +: DATA_W]. Each slave presents data one cycle after it is selected.
- hold_o  out  1  stall request to control.

## Operation

- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - With any request, the winner is chosen by fixed priority M2 > M1 > M0.
  - The grant index, we, addr and wdata are latched into registers, and the FSM moves to ACCESS.
  - With no request, the FSM stays in IDLE.
- **ACCESS:**
  - Slave index = latched addr[SEL_MSB:SEL_LSB].
  - If the index is < NUM_SLV: s_sel_o is one-hot for that index, and s_we_o = latched we. s_addr_o and s_wdata_o carry the latched values.
  - A valid write ends here: the winner's done is pulsed, and the FSM goes to IDLE.
  - A valid read goes to RESP.
  - If the index is ≥ NUM_SLV: s_sel_o = 0 and s_we_o = 0. The winner gets done = 1, err = 1 and rdata = 0 in this cycle, and the FSM goes to IDLE. This applies to both reads and writes.
- **RESP:**
  - s_sel_o = 0.
  - The winner's rdata is driven from s_rdata_i slice[index], and its done is pulsed (err = 0).
  - The FSM goes to IDLE.
- **Non-winners:** done, err and rdata are 0 at all times.
- **No pre-emption:** a request arriving while not in IDLE waits; a higher-priority arrival does not abort the transaction in flight.
- **Starvation:** M0 can starve under continuous M1/M2 traffic. This is accepted because the core is held during M1 traffic.
- **Dropped request:** if a master drops req before done, the transaction still completes and the done pulse is ignored. This is a protocol violation, but the FSM must not hang.
- **hold_o:** = m1_req_i & ~m1_done_o. This is combinational.
- **Reset:**
  - Asynchronous; applies at any state, including mid-transaction.
  - FSM → IDLE; latched fields cleared to 0.
  - All outputs 0, except that hold_o follows its equation (it is 1 if m1_req_i is high).
  - No slave strobe is emitted during or after reset until a new grant.

## Timing

- **Write:** request seen in IDLE at cycle T → slave strobe and done in cycle T+1. A master can start its next request at T+2 at the earliest.
- **Read:** request seen in IDLE at cycle T → select in cycle T+1 → slave data and done in cycle T+2. Minimum 3 cycles between read grants.
- **Decode error:** done and err in cycle T+1.
- **Back-to-back:** the arbiter re-enters IDLE and re-arbitrates on the cycle after done. There is no zero-bubble turnaround.
- **Output registration:** s_* outputs are driven from registers only. Master rdata is combinational from s_rdata_i in RESP.

## Structure

- Shared package: a state enum `rib_state_e` and master index constants `RIB_M_IF` = 0, `RIB_M_LS` = 1, `RIB_M_DBG` = 2.
- Width macros come from the existing defines header.
- One natural sub-module, `rib_prio_enc`: a combinational 3-input fixed-priority encoder producing a grant index and a valid flag.

## Test plan

- **Single write:** M1 writes 0xDEADBEEF to 0x1000_0040 → cycle T+1: s_sel_o = 4'b0010, s_we_o = 1, s_addr_o = 0x1000_0040, m1_done_o = 1. hold_o high during T..T+1.
- **Single read:** M0 reads 0x0000_0100; slave 0 returns 0x00000013 → m0_done_o at T+2 with m0_rdata_o = 0x00000013, err = 0.
- **Arbitration:** M0, M1 and M2 all request in the same cycle → completion order is M2, M1, M0. Each grant begins the cycle after the previous done; no overlap of s_sel_o.
- **Decode error:** M2 reads 0x5000_0000 with NUM_SLV = 4 → s_sel_o stays 0; m2_done_o = 1, m2_err_o = 1, rdata = 0 at T+1.
- **Reset mid-read:** rst_i asserted while in ACCESS → s_sel_o = 0 immediately and no done pulse. After release, a pending M1 request is re-granted from IDLE and completes normally.
- **Late arrival:** M0 is mid-read when M2 requests → M0 completes first, then M2 is served; M0's data is unaffected.
